// File: rtl/exu_mdu_sched.sv
// rtl/exu_mdu_sched.sv - EX-stage issue scheduler steering results between ALU and shared MDU
//
// Purpose:
//   Accepts one op at a time from ID/EX. ALU ops and RISC-V divide corner cases
//   complete in one cycle. Every other M-extension op starts the iterative MDU,
//   steps it LAT times and captures md_result on the final step. The result is
//   held in ResultE until MEM takes it.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   Dvalid / Eready           upstream handshake (accept = Dvalid & Eready)
//   op_is_md, md_op           M-extension select and funct3
//   SrcA, SrcB, alu_result    operands and combinational ALU result
//   flush                     kill in-flight or held op
//   md_start/md_step/md_abort MDU sequencing controls
//   md_result                 MDU result, valid on the final step cycle
//   Evalid / Mready           downstream handshake
//   ResultE                   registered EX result
//   perf_md_ops, perf_md_busy performance counters (only with EXU_MDU_PERF_EN)
//
// Optional feature macro: EXU_MDU_PERF_EN

module exu_mdu_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  Dvalid,
    output logic                  Eready,
    input  logic                  op_is_md,
    input  logic [2:0]            md_op,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  flush,
    output logic                  md_start,
    output logic                  md_step,
    output logic                  md_abort,
    input  logic [DATA_WIDTH-1:0] md_result,
    output logic                  Evalid,
    input  logic                  Mready,
`ifdef EXU_MDU_PERF_EN
    output logic [31:0]           perf_md_ops,
    output logic [31:0]           perf_md_busy,
`endif
    output logic [DATA_WIDTH-1:0] ResultE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [DATA_WIDTH-1:0] INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]      MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  b_zero, div_ovf, short_hit;
    logic [DATA_WIDTH-1:0] short_val;
    logic                  slot_open, accept, launch_md;

    // Divide corner cases resolved without the MDU. md_op[2]=divide class,
    // md_op[1]=remainder, md_op[0]=unsigned. Overflow only applies to signed ops.
    always_comb begin
        b_zero    = (SrcB == '0);
        div_ovf   = (SrcA == INT_MIN) && (SrcB == ALL_ONES);
        short_hit = md_op[2] && (b_zero || (!md_op[0] && div_ovf));
        if (b_zero) begin
            short_val = md_op[1] ? SrcA : ALL_ONES;
        end else begin
            short_val = md_op[1] ? '0 : INT_MIN;
        end
    end

    // slot_open ignores flush so md_abort can report a start that flush suppressed.
    assign slot_open = (state_q == S_IDLE) || ((state_q == S_HOLD) && Mready);
    assign Eready    = slot_open && !flush;
    assign accept    = Dvalid && Eready;
    assign launch_md = Dvalid && slot_open && op_is_md && !short_hit;

    assign md_start  = launch_md && !flush;
    assign md_step   = (state_q == S_RUN);
    assign md_abort  = flush && ((state_q == S_RUN) || launch_md);
    assign Evalid    = (state_q == S_HOLD);
    assign ResultE   = result_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        if (!op_is_md) begin
                            result_d = alu_result;
                            state_d  = S_HOLD;
                        end else if (short_hit) begin
                            result_d = short_val;
                            state_d  = S_HOLD;
                        end else begin
                            cnt_d   = md_op[2] ? DIV_LAST : MUL_LAST;
                            state_d = S_RUN;
                        end
                    end else if (state_q == S_HOLD && Mready) begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        result_d = md_result;
                        state_d  = S_HOLD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

`ifdef EXU_MDU_PERF_EN
    logic [31:0] ops_q, busy_q;

    // A run completes only when its final step is not flushed; busy counts
    // every RUN cycle, including those of a run that is later aborted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ops_q  <= '0;
            busy_q <= '0;
        end else begin
            if (state_q == S_RUN && busy_q != '1) begin
                busy_q <= busy_q + 32'd1;
            end
            if (state_q == S_RUN && cnt_q == '0 && !flush && ops_q != '1) begin
                ops_q <= ops_q + 32'd1;
            end
        end
    end

    assign perf_md_ops  = ops_q;
    assign perf_md_busy = busy_q;
`endif

endmodule
